dtree_frame_loader: RTL and testbench



---
 rtl/dtree_pkg.sv | 20 ++
 rtl/dtree_settle_timer.sv | 26 ++
 rtl/dtree_frame_loader.sv | 99 +++++++++
 tb/tb_dtree_frame_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree classifier front end: default
// geometry, loader FSM states and the feature-slice helper.
package dtree_pkg;

  localparam int NUM_FEATURES_DEF = 9;
  localparam int FEAT_W_DEF       = 8;
  localparam int CLASS_W_DEF      = 2;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } loader_state_e;

  // Lowest bit of feature slot idx on the flattened feature bus.
  function automatic int feat_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/dtree_settle_timer.sv
// 8-bit down counter with synchronous load, count enable and zero flag;
// times how long the feature bus is held before the class is sampled.
module dtree_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/dtree_frame_loader.sv
// Assembles a byte stream into the parallel feature bus of the combinational
// tree, holds it for a settle time, then returns the sampled class.
module dtree_frame_loader #(
  parameter int NUM_FEATURES  = dtree_pkg::NUM_FEATURES_DEF,
  parameter int FEAT_W        = dtree_pkg::FEAT_W_DEF,
  parameter int CLASS_W       = dtree_pkg::CLASS_W_DEF,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FEAT_W-1:0]              in_data,
  input  logic                           in_last,
  output logic [NUM_FEATURES*FEAT_W-1:0] feat_bus,
  input  logic [CLASS_W-1:0]             tree_class,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [CLASS_W-1:0]             res_class,
  output logic                           res_err
);
  import dtree_pkg::*;

  localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  loader_state_e    state;
  logic [IDX_W-1:0] idx;
  logic             err_r;
  logic             accept;
  logic             at_last;
  logic             good_last;
  logic             settle_done;

  assign in_ready  = (state == LOAD);
  assign res_valid = (state == OUT);
  assign res_err   = err_r;

  assign accept    = in_valid & in_ready;
  assign at_last   = (idx == LAST_IDX);
  assign good_last = accept & in_last & at_last;

  dtree_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (good_last),
    .load_val (8'(SETTLE_CYCLES - 1)),
    .en       ((state == SETTLE) && !settle_done),
    .zero     (settle_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      idx       <= '0;
      err_r     <= 1'b0;
      res_class <= '0;
      feat_bus  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            // The byte is stored even when it turns out to break framing.
            for (int i = 0; i < NUM_FEATURES; i++) begin
              if (idx == IDX_W'(i)) begin
                feat_bus[feat_lsb(i, FEAT_W) +: FEAT_W] <= in_data;
              end
            end
            if (in_last && at_last) begin
              idx   <= '0;
              state <= SETTLE;
            end else if (!in_last && !at_last) begin
              idx <= idx + 1'b1;
            end else begin
              idx       <= '0;
              err_r     <= 1'b1;
              res_class <= '0;
              state     <= OUT;
            end
          end
        end
        SETTLE: begin
          if (settle_done) begin
            res_class <= tree_class;
            err_r     <= 1'b0;
            state     <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_frame_loader.sv
// Self-checking bench for dtree_frame_loader: table of frames with a
// result scoreboard, plus hold and reset-during-settle sequences.
module tb_dtree_frame_loader;

  localparam int NF = 9;
  localparam int FW = 8;
  localparam int CW = 2;
  localparam int SC = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [FW-1:0]     in_data = '0;
  logic              in_last = 1'b0;
  logic [NF*FW-1:0]  feat_bus;
  logic [CW-1:0]     tree_class = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [CW-1:0]     res_class;
  logic              res_err;

  dtree_frame_loader #(
    .NUM_FEATURES (NF),
    .FEAT_W       (FW),
    .CLASS_W      (CW),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .feat_bus   (feat_bus),
    .tree_class (tree_class),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_class  (res_class),
    .res_err    (res_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    bit         last_on_end;
    int         base;
    logic [1:0] cls;
    bit         err;
    bit         rnd;
    bit         hold;
  } vec_t;

  typedef struct {
    logic [CW-1:0]    cls;
    logic             err;
    logic [NF*FW-1:0] feat;
  } exp_t;

  exp_t             exp_q[$];
  logic [NF*FW-1:0] model_feat = '0;
  int               model_idx  = 0;
  int               tests = 0;
  int               fails = 0;
  vec_t             vecs[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every result handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result actual=class%0h/err%0b required=none", res_class, res_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_class", 128'(res_class), 128'(e.cls));
        chk("res_err", 128'(res_err), 128'(e.err));
        chk("feat_bus", 128'(feat_bus), 128'(e.feat));
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l, input bit rnd);
    bit acc;
    int gap;
    gap = rnd ? int'($urandom_range(0, 2)) : 0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    if (rnd) tree_class = CW'($urandom);
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) chk("byte_accept_timeout", 128'(acc), 128'(1));
    model_feat[model_idx*FW +: FW] = d;
    if (l || model_idx == NF - 1) model_idx = 0;
    else model_idx++;
  endtask

  task automatic wait_load();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = in_ready;
    end
    if (!seen) chk("return_to_load_timeout", 128'(seen), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    exp_t e;
    int   k;
    bit   ok;
    logic [CW-1:0]    snap_cls;
    logic [NF*FW-1:0] snap_feat;
    if (!v.rnd) tree_class = v.cls;
    res_ready = v.hold ? 1'b0 : 1'b1;
    for (int i = 0; i < v.n; i++) begin
      send_byte(8'(v.base + i), (i == v.n - 1) && v.last_on_end, v.rnd);
    end
    tree_class = v.cls;
    e.cls  = v.err ? '0 : v.cls;
    e.err  = v.err;
    e.feat = model_feat;
    exp_q.push_back(e);
    k = 0;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      k++;
      ok = res_valid;
    end
    chk("result_latency", 128'(k), 128'(v.err ? 1 : SC + 1));
    if (v.hold) begin
      snap_cls  = res_class;
      snap_feat = feat_bus;
      ok = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (!res_valid || in_ready || res_class !== snap_cls || feat_bus !== snap_feat) ok = 1'b0;
      end
      chk("hold_stable", 128'(ok), 128'(1));
      @(posedge clk);
      #1;
      res_ready = 1'b1;
    end
    wait_load();
  endtask

  initial begin
    vecs[0] = '{n: 9, last_on_end: 1, base: 8'h00, cls: 2'd2, err: 0, rnd: 0, hold: 0};
    vecs[1] = '{n: 9, last_on_end: 1, base: 8'h00, cls: 2'd2, err: 0, rnd: 0, hold: 1};
    vecs[2] = '{n: 4, last_on_end: 1, base: 8'h40, cls: 2'd1, err: 1, rnd: 0, hold: 0};
    vecs[3] = '{n: 9, last_on_end: 1, base: 8'h10, cls: 2'd1, err: 0, rnd: 0, hold: 0};
    vecs[4] = '{n: 9, last_on_end: 0, base: 8'h20, cls: 2'd2, err: 1, rnd: 0, hold: 0};
    vecs[5] = '{n: 9, last_on_end: 1, base: 8'h30, cls: 2'd0, err: 0, rnd: 0, hold: 0};
    vecs[6] = '{n: 9, last_on_end: 1, base: 8'h50, cls: 2'd3, err: 0, rnd: 1, hold: 0};
    vecs[7] = '{n: 9, last_on_end: 1, base: 8'hF7, cls: 2'd1, err: 0, rnd: 0, hold: 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_res_class", 128'(res_class), 128'(0));
    chk("rst_res_err", 128'(res_err), 128'(0));
    chk("rst_feat_bus", 128'(feat_bus), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) run_frame(vecs[v]);

    // Reset pulsed while the bus is settling: frame and result are dropped.
    tree_class = 2'd1;
    for (int i = 0; i < NF; i++) send_byte(8'(8'h70 + i), i == NF - 1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_feat_bus", 128'(feat_bus), 128'(0));
    chk("midreset_in_ready", 128'(in_ready), 128'(1));
    chk("midreset_res_valid", 128'(res_valid), 128'(0));
    model_feat = '0;
    model_idx  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      bit quiet;
      quiet = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (res_valid) quiet = 1'b0;
      end
      chk("no_result_after_reset", 128'(quiet), 128'(1));
      chk("post_reset_in_ready", 128'(in_ready), 128'(1));
    end
    @(posedge clk);
    #1;
    run_frame('{n: 9, last_on_end: 1, base: 8'h60, cls: 2'd2, err: 0, rnd: 0, hold: 0});

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
